// File: rtl/gzip_job_sched_pkg.sv
// Shared types and constants for the gzip job scheduler.
package gzip_job_sched_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CORE_RST = 2'd1,
    ST_RUN      = 2'd2,
    ST_REPORT   = 2'd3
  } state_t;

  // Completion status codes
  localparam logic [1:0] STS_OK        = 2'b00;
  localparam logic [1:0] STS_BTYPE_ERR = 2'b01;
  localparam logic [1:0] STS_BLK_ERR   = 2'b10;
  localparam logic [1:0] STS_TIMEOUT   = 2'b11;

  // DEFLATE block types
  localparam logic [1:0] BTYPE_STORED  = 2'b00;
  localparam logic [1:0] BTYPE_FIXED   = 2'b01;
  localparam logic [1:0] BTYPE_DYNAMIC = 2'b10;
  localparam logic [1:0] BTYPE_ILLEGAL = 2'b11;

  // Status for a normal end-of-stream: block-size error outranks btype error
  function automatic logic [1:0] done_code(input logic blk_err, input logic btype_err);
    logic [1:0] code;
    code = STS_OK;
    if (blk_err) begin
      code = STS_BLK_ERR;
    end else if (btype_err) begin
      code = STS_BTYPE_ERR;
    end
    return code;
  endfunction

endpackage

// File: rtl/gzip_job_sched_if.sv
// Job request / completion status handshake bundle.
interface gzip_job_sched_if;
  logic        job_valid;
  logic        job_ready;
  logic [1:0]  job_btype;
  logic        sts_valid;
  logic        sts_ready;
  logic [1:0]  sts_code;
  logic [31:0] sts_isize;
  logic [31:0] sts_crc;

  // Job submitter / status consumer side
  modport master (
    output job_valid, job_btype, sts_ready,
    input  job_ready, sts_valid, sts_code, sts_isize, sts_crc
  );

  // Scheduler side
  modport slave (
    input  job_valid, job_btype, sts_ready,
    output job_ready, sts_valid, sts_code, sts_isize, sts_crc
  );
endinterface

// File: rtl/gzip_job_sched_watchdog.sv
// Saturating cycle counter that flags when it reaches a programmable limit.
module gzip_watchdog #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Clear has priority; otherwise count up while enabled and hold at all-ones
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A zero limit disables expiry
  assign expired = enable && (limit != '0) && (count_q == limit);

endmodule

// File: rtl/gzip_job_sched.sv
// Sequences one compression job at a time: holds the core in reset,
// runs it under a watchdog, and reports a completion record.
module gzip_job_sched
  import gzip_job_sched_pkg::*;
#(
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT_W  = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  gzip_job_sched_if.slave      job,
  input  logic [TIMEOUT_W-1:0] timeout_cfg,
  input  logic                 abort,
  output logic                 core_rst_n,
  output logic [1:0]           core_btype,
  input  logic                 core_done,
  input  logic                 core_btype_err,
  input  logic                 core_blk_err,
  input  logic [31:0]          core_isize,
  input  logic [31:0]          core_crc,
  output logic                 busy
);

  localparam logic [3:0] RST_CNT_INIT = 4'(RST_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  rst_cnt_q, rst_cnt_d;
  logic [1:0]  btype_q, btype_d;
  logic [1:0]  sts_code_q, sts_code_d;
  logic [31:0] sts_isize_q, sts_isize_d;
  logic [31:0] sts_crc_q, sts_crc_d;
  logic        wd_expired;

  // Watchdog is held clear through core reset so it starts from 0 in RUN
  gzip_watchdog #(.W(TIMEOUT_W)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q == ST_CORE_RST),
    .enable  (state_q == ST_RUN),
    .limit   (timeout_cfg),
    .expired (wd_expired)
  );

  // Next-state and completion-record capture
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    btype_d     = btype_q;
    sts_code_d  = sts_code_q;
    sts_isize_d = sts_isize_q;
    sts_crc_d   = sts_crc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (job.job_valid) begin
          if (job.job_btype == BTYPE_ILLEGAL) begin
            // Rejected without ever releasing the core
            state_d     = ST_REPORT;
            sts_code_d  = STS_BTYPE_ERR;
            sts_isize_d = '0;
            sts_crc_d   = '0;
          end else begin
            btype_d   = job.job_btype;
            rst_cnt_d = RST_CNT_INIT;
            state_d   = ST_CORE_RST;
          end
        end
      end
      ST_CORE_RST: begin
        if (abort) begin
          state_d     = ST_REPORT;
          sts_code_d  = STS_TIMEOUT;
          sts_isize_d = core_isize;
          sts_crc_d   = core_crc;
        end else begin
          rst_cnt_d = rst_cnt_q - 4'd1;
          if (rst_cnt_q <= 4'd1) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // abort beats core_done, which beats watchdog expiry
        if (abort) begin
          state_d     = ST_REPORT;
          sts_code_d  = STS_TIMEOUT;
          sts_isize_d = core_isize;
          sts_crc_d   = core_crc;
        end else if (core_done) begin
          state_d     = ST_REPORT;
          sts_code_d  = done_code(core_blk_err, core_btype_err);
          sts_isize_d = core_isize;
          sts_crc_d   = core_crc;
        end else if (wd_expired) begin
          state_d     = ST_REPORT;
          sts_code_d  = STS_TIMEOUT;
          sts_isize_d = core_isize;
          sts_crc_d   = core_crc;
        end
      end
      ST_REPORT: begin
        if (job.sts_ready) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State and record registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rst_cnt_q   <= '0;
      btype_q     <= BTYPE_STORED;
      sts_code_q  <= STS_OK;
      sts_isize_q <= '0;
      sts_crc_q   <= '0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      btype_q     <= btype_d;
      sts_code_q  <= sts_code_d;
      sts_isize_q <= sts_isize_d;
      sts_crc_q   <= sts_crc_d;
    end
  end

  assign job.job_ready = (state_q == ST_IDLE) && !rst;
  assign job.sts_valid = (state_q == ST_REPORT);
  assign job.sts_code  = sts_code_q;
  assign job.sts_isize = sts_isize_q;
  assign job.sts_crc   = sts_crc_q;
  assign core_rst_n    = (state_q == ST_RUN);
  assign core_btype    = btype_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: doc/gzip_job_sched.md
GZIP_JOB_SCHED -- requirements
Module: gzip_job_sched

Interface
REQ-001 Parameter RST_CYCLES, default 4, cycles core reset is held low before each job (1..15).
REQ-002 Parameter TIMEOUT_W, default 24, watchdog counter width.
REQ-003 clk  input  1  core clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 job_valid  input  1  job request; held until accepted.
REQ-006 job_ready  output  1  job acceptance; transfer when job_valid && job_ready.
REQ-007 job_btype  input  2  requested compression mode (00 stored, 01 fixed Huffman, 10 dynamic, 11 illegal).
REQ-008 timeout_cfg  input  TIMEOUT_W  watchdog limit in cycles; 0 disables the watchdog.
REQ-009 abort  input  1  single-cycle job cancel request.
REQ-010 core_rst_n  output  1  active-low reset to the compression core.
REQ-011 core_btype  output  2  mode driven to the core.
REQ-012 core_done  input  1  core end-of-stream flag (level).
REQ-013 core_btype_err, core_blk_err  input  1 each  core error flags (level).
REQ-014 core_isize, core_crc  input  32 each  core ISIZE and CRC32.
REQ-015 sts_valid  output  1  completion record valid; held until sts_ready.
REQ-016 sts_ready  input  1  completion record accept.
REQ-017 sts_code  output  2  00 ok, 01 btype error, 10 block-size error, 11 timeout/abort.
REQ-018 sts_isize, sts_crc  output  32 each  captured ISIZE/CRC32.
REQ-019 busy  output  1  high in every state except IDLE.

Function
REQ-020 FSM states: IDLE, CORE_RST, RUN, REPORT; encoding one-hot or binary at implementer's choice.
REQ-021 IDLE: job_ready=1; on accepted job with btype!=11, latch btype into core_btype, load reset counter, go CORE_RST next cycle.
REQ-022 IDLE: accepted job with btype=11 goes directly to REPORT with sts_code=01, sts_isize=0, sts_crc=0; core is not released from reset.
REQ-023 CORE_RST: core_rst_n=0 for exactly RST_CYCLES cycles, then RUN; watchdog cleared on entry to RUN.
REQ-024 RUN: core_rst_n=1; watchdog increments each cycle, saturating at all-ones.
REQ-025 RUN: core_done=1 captures core_isize/core_crc into sts_* in the same edge and goes REPORT; sts_code=10 if core_blk_err, else 01 if core_btype_err, else 00.
REQ-026 RUN: watchdog == timeout_cfg (timeout_cfg!=0) without core_done -> REPORT, sts_code=11, sts_isize=core_isize, sts_crc=core_crc.
REQ-027 Same cycle core_done and watchdog expiry: core_done wins.
REQ-028 abort in CORE_RST or RUN -> REPORT with sts_code=11, overriding core_done/timeout in that cycle; abort ignored in IDLE and REPORT.
REQ-029 REPORT: sts_valid=1, sts_* stable; core_rst_n=0; on sts_ready go IDLE; job_ready=0.
REQ-030 Back-to-back: job_ready rises the cycle after the status handshake; minimum job-to-job spacing RST_CYCLES+3 cycles.
REQ-031 core_btype holds last accepted legal btype outside active jobs.
REQ-032 job_ready and sts_valid never high together.

Reset
REQ-033 rst=1 at any edge forces IDLE regardless of state, including mid-RUN and mid-REPORT; no status record is emitted for the interrupted job.
REQ-034 Reset values: core_rst_n=0, core_btype=00, job_ready=0 during rst then 1 in IDLE, sts_valid=0, sts_code=00, sts_isize=0, sts_crc=0, busy=0, counters 0.

Structure
REQ-035 Shared package holds FSM state type, sts_code constants (STS_OK, STS_BTYPE_ERR, STS_BLK_ERR, STS_TIMEOUT) and btype constants.
REQ-036 One sub-module, gzip_watchdog (clear, enable, limit, expired, saturating); all else flat.

Verification
REQ-037 job btype=01, RST_CYCLES=4, core_done after 100 cycles with isize=0x00000400, crc=0xCBF43926 -> core_rst_n low 4 cycles, sts_code=00, sts_isize=0x400, sts_crc=0xCBF43926.
REQ-038 job btype=11 -> core_rst_n never rises, sts_valid next cycle with sts_code=01, isize/crc 0.
REQ-039 timeout_cfg=50, core_done never asserted -> REPORT after 50 RUN cycles, sts_code=11; repeat with timeout_cfg=0 -> no timeout in 10000 cycles.
REQ-040 abort and core_done same cycle in RUN -> sts_code=11; core_done with core_blk_err=1 and core_btype_err=1 -> sts_code=10.
REQ-041 sts_ready held low 20 cycles -> sts_* stable, job_ready=0, new job_valid not accepted until after handshake.
REQ-042 rst asserted mid-RUN -> next cycle IDLE, core_rst_n=0, sts_valid=0, busy=0; following job completes normally.
